// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bit 1 of the op code selects divide; bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// Accumulator layout is {hi_half, lo_half}: multiply keeps {partial, multiplier},
// divide keeps {remainder, dividend/quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    mul_next = {mul_sum, acc_i[WIDTH-1:1]};

    // The remainder stays below the divisor, so it always fits in WIDTH bits;
    // only the shifted partial remainder needs the extra bit for the compare.
    div_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_i});
    div_diff  = div_shift[WIDTH-1:0] - opnd_i;
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_i[WIDTH-2:0], div_ge};

    acc_o = is_div_i ? div_next : mul_next;
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning all HI/LO writes.
// FSM: IDLE -> CALC (WIDTH cycles) -> FIXUP -> DONE -> IDLE; divide-by-zero skips to DONE.
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             HiLoWrite,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               launch;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    launch    = Start & ~Flush & (state_q == S_IDLE);
    op_signed = op_is_signed(Op);
    // -INT_MIN wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    a_mag     = (op_signed && OpA[WIDTH-1]) ? -OpA : OpA;
    b_mag     = (op_signed && OpB[WIDTH-1]) ? -OpB : OpB;

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          is_div_d = op_is_div(Op);
          sign_a_d = op_signed & OpA[WIDTH-1];
          sign_b_d = op_signed & OpB[WIDTH-1];
          cnt_d    = '0;
          dbz_d    = 1'b0;
          if (op_is_div(Op) && (OpB == '0)) begin
            hi_d    = OpA;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else if (op_is_div(Op)) begin
            opnd_d  = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            state_d = S_CALC;
          end else begin
            opnd_d  = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE is already committed; a Flush here cannot retract the write.
        dbz_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Stall     = Busy | (Start & (state_q == S_IDLE) & ~Flush);
  assign Done      = (state_q == S_DONE);
  assign HiLoWrite = Done;
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign DivByZero = Done & dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed self-checking bench for hilo_muldiv_sequencer with hand-computed results.
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [1:0]   Op = 2'd0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic         Busy, Stall, Done, HiLoWrite, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .OpA       (OpA),
    .OpB       (OpB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .HiLoWrite (HiLoWrite),
    .HiOut     (HiOut),
    .LoOut     (LoOut),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Launch in cycle 0, wait (bounded) for Done, then check latency and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz, input int exp_lat);
    int cyc;
    int busy_bad;
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    #1;
    chk({tag, " stall_c0"}, 64'(Stall), 64'd1);
    chk({tag, " busy_c0"}, 64'(Busy), 64'd0);
    tick();
    Start = 1'b0;
    cyc = 1;
    busy_bad = 0;
    while (!Done && cyc < 60) begin
      if (!(Busy && Stall)) busy_bad++;
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " busy_gaps"}, 64'(busy_bad), 64'd0);
    chk({tag, " busy_stall_done"}, 64'({Busy, Stall}), 64'b11);
    chk({tag, " hilowrite"}, 64'(HiLoWrite), 64'd1);
    chk({tag, " hi"}, 64'(HiOut), 64'(exp_hi));
    chk({tag, " lo"}, 64'(LoOut), 64'(exp_lo));
    chk({tag, " dbz"}, 64'(DivByZero), 64'(exp_dbz));
    tick();
    chk({tag, " idle_after"}, 64'({Busy, Done}), 64'd0);
    chk({tag, " hi_hold"}, 64'(HiOut), 64'(exp_hi));
  endtask

  initial begin
    int done_cnt;
    int done_cyc;

    #3;
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset stall", 64'(Stall), 64'd0);
    chk("reset hilo", 64'({HiOut, LoOut}), 64'd0);
    #9 Rst = 1'b1;
    tick();

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("mult_intmin_sq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
    run_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("div_by0", 2'd2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);

    // Flush during CALC at cycle 10
    Start = 1'b1; Op = 2'd1; OpA = 32'd2; OpB = 32'd3;
    tick();
    Start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (Done) done_cnt++;
      if (c == 10) Flush = 1'b1;
      tick();
    end
    Flush = 1'b0;
    chk("flush idle_c11", 64'(Busy), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (Done || HiLoWrite) done_cnt++;
      tick();
    end
    chk("flush no_write", 64'(done_cnt), 64'd0);
    chk("flush hilo_kept", 64'({HiOut, LoOut}), {32'h0, 32'h8000_0000});

    // Flush wins over Start in IDLE
    Start = 1'b1; Flush = 1'b1; Op = 2'd1; OpA = 32'd9; OpB = 32'd9;
    #1;
    chk("flush_start stall", 64'(Stall), 64'd0);
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start no_launch", 64'(Busy), 64'd0);

    run_op("after_flush", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);

    // Flush in DONE does not cancel the write
    Start = 1'b1; Op = 2'd3; OpA = 32'd5; OpB = 32'd0;
    tick();
    Start = 1'b0; Flush = 1'b1;
    #1;
    chk("flush_done write", 64'({Done, HiLoWrite, DivByZero}), 64'b111);
    tick();
    Flush = 1'b0;
    chk("flush_done idle", 64'(Busy), 64'd0);
    chk("flush_done hilo", 64'({HiOut, LoOut}), {32'd5, 32'hFFFF_FFFF});

    // Second Start during CALC is ignored
    Start = 1'b1; Op = 2'd1; OpA = 32'd3; OpB = 32'd5;
    tick();
    Start = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        Start = 1'b1; Op = 2'd3; OpA = 32'd100; OpB = 32'd0;
        #1;
        chk("restart stall", 64'(Stall), 64'd1);
      end
      if (Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      tick();
      if (c == 5) Start = 1'b0;
    end
    chk("restart done_count", 64'(done_cnt), 64'd1);
    chk("restart done_cycle", 64'(done_cyc), 64'd34);
    chk("restart hilo", 64'({HiOut, LoOut}), {32'd0, 32'd15});

    // Asynchronous reset mid-operation at cycle 15
    Start = 1'b1; Op = 2'd1; OpA = 32'h0001_0000; OpB = 32'h0001_0000;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    #2 Rst = 1'b0;
    #1;
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst done", 64'(Done), 64'd0);
    chk("rst hilo", 64'({HiOut, LoOut}), 64'd0);
    #2 Rst = 1'b1;
    tick();
    chk("rst stays_idle", 64'({Busy, Done}), 64'd0);
    run_op("after_rst", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
